cascaded_mod_counter: RTL and testbench
=======================================

CASCADED_MOD_COUNTER -- requirements
Module: cascaded_mod_counter

Interface
REQ-001 SHALL have parameter MOD, default 10: per-digit modulus, legal range 2..16.
REQ-002 SHALL have parameter DIGITS, default 4: number of cascaded digits, legal range 1..8.
REQ-003 SHALL derive localparam W = clog2(MOD), the per-digit width, e.g. W=4 for MOD=10.
REQ-004 clk  input  1  rising-edge clock; the block's only clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; counts one step per cycle when high.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  parallel load request.
REQ-009 din  input  DIGITS*W  load value; digit i occupies bits [i*W +: W], and digit 0 is least significant.
REQ-010 q  output  DIGITS*W  count value, packed like din.
REQ-011 tc  output  1  terminal count, combinational.
REQ-012 wrap  output  1  registered one-cycle pulse when the whole counter wraps.
REQ-013 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-014 Priority each cycle SHALL be rst > load > en; when none is active, q SHALL hold.
REQ-015 Digit i SHALL step only when en=1 and every lower digit is at its terminal value for the current direction; digit 0 steps whenever en=1.
REQ-016 Terminal value: MOD-1 when up=1, 0 when up=0.
REQ-017 Up step: a digit at value >= MOD-1 SHALL go to 0; otherwise it SHALL go to value+1. Out-of-range values therefore recover to 0.
REQ-018 Down step: a digit at 0 SHALL go to MOD-1; a digit at value > MOD-1 SHALL go to MOD-1; otherwise it SHALL go to value-1.
REQ-019 tc SHALL equal en AND (all digits at terminal for current up); tc SHALL be 0 when en=0.
REQ-020 wrap SHALL be 1 in the cycle after a clock edge where tc=1 was sampled with load=0 and rst=0, and 0 otherwise.
REQ-021 load=1 with every din digit < MOD SHALL set q=din at the next edge, regardless of en.
REQ-022 load=1 with any din digit >= MOD SHALL leave q unchanged, ignore en that cycle, and pulse load_err for one cycle.
REQ-023 Direction changes SHALL take effect in the same cycle; no pipeline is allowed, so q updates exactly one edge after its cause.
REQ-024 Latency from en/load to q SHALL be 1 clock; tc SHALL have zero latency.

Reset
REQ-025 On rst=1 at an edge: q=0, wrap=0, load_err=0.
REQ-026 rst asserted mid-count or together with load/en SHALL override both; counting SHALL resume from 0 on the first edge after rst deasserts, if en=1.

Structure
REQ-027 The shared package counters_pkg SHALL hold the clog2 width function and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-028 A single sub-module, mod_n_digit, SHALL be used. It is parametrised by MOD, with ports clk, rst, en_in, up, load, d, q, and a combinational terminal output. It SHALL be instantiated DIGITS times through a generate loop, with carry chained by terminal outputs.
REQ-029 Load validation (per-digit range check, AND-reduced) SHALL live in the top level.

Verification (MOD=10, DIGITS=2)
REQ-030 rst=1 for 2 cycles, then en=1, up=1 for 100 cycles: q steps 00..99. tc=1 at q=99. q returns to 00 with wrap=1 for exactly one cycle. No value >9 appears in any digit.
REQ-031 Load din=0x05 with up=0, en=1: q goes 05,04..00,99,98. tc=1 at q=00. wrap pulses after the 00->99 transition.
REQ-032 load=1, din=0x3A (digit 0 = 10): q holds its prior value and load_err pulses once. load=1, din=0x39 next: q=39 and no error.
REQ-033 At q=19, up=1, en=1: next q=20 (carry into digit 1). Switch to up=0 at q=20: next q=19 (borrow).
REQ-034 rst=1 asserted together with load=1, din=0x55, en=1, at q=47: q=00 next cycle, with wrap=0 and load_err=0.
REQ-035 Toggle en=0 for 3 cycles at q=62: q holds at 62, tc=0 throughout, and counting resumes at 63 when en returns to 1.

Source files
------------

// File: rtl/counters_pkg.sv
// counters_pkg
//   Shared definitions for the counter blocks.
//   clog2     : bit width needed to hold the values 0..n-1 (returns 1 for n=2)
//   DIR_UP    : value of 'up' that selects counting up
//   DIR_DOWN  : value of 'up' that selects counting down
package counters_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cascaded_mod_counter_if.sv
// cascaded_mod_counter_if
//   Control and status bundle for cascaded_mod_counter.
//   en, up, load, din : driven by the controlling side (master)
//   q, tc, wrap, load_err : driven by the counter (slave)
//   Signalling: there is no valid/ready pair. Every input is a level that is
//   sampled on each rising clk edge; q, wrap and load_err are registered,
//   and tc is combinational from en, up and q.
interface cascaded_mod_counter_if #(
    parameter int MOD    = 10,
    parameter int DIGITS = 4
);
    import counters_pkg::*;

    localparam int W = clog2(MOD);

    logic                en;
    logic                up;
    logic                load;
    logic [DIGITS*W-1:0] din;
    logic [DIGITS*W-1:0] q;
    logic                tc;
    logic                wrap;
    logic                load_err;

    modport master (
        output en, up, load, din,
        input  q, tc, wrap, load_err
    );

    modport slave (
        input  en, up, load, din,
        output q, tc, wrap, load_err
    );

endinterface

// File: rtl/mod_n_digit.sv
// mod_n_digit
//   One modulo-MOD digit of the cascaded counter.
//   clk, rst  : clock, synchronous active-high reset (q -> 0)
//   en_in     : step this cycle (already gated by the lower-digit carry chain)
//   up        : direction, DIR_UP / DIR_DOWN
//   load, d   : parallel load (caller only asserts load for an in-range d)
//   q         : digit value
//   terminal  : combinational, q is at the last value for the current direction
module mod_n_digit #(
    parameter int MOD = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en_in,
    input  logic                                 up,
    input  logic                                 load,
    input  logic [counters_pkg::clog2(MOD)-1:0]  d,
    output logic [counters_pkg::clog2(MOD)-1:0]  q,
    output logic                                 terminal
);
    import counters_pkg::*;

    localparam int            W   = clog2(MOD);
    localparam logic [W-1:0]  TOP = W'(MOD - 1);

    logic [W-1:0] q_next;

    // Out-of-range values fold back into the legal range on the next step:
    // to 0 when counting up, to MOD-1 when counting down.
    always_comb begin
        q_next = q;
        if (up == DIR_UP) begin
            q_next = (q >= TOP) ? '0 : q + 1'b1;
        end else begin
            q_next = ((q == '0) || (q > TOP)) ? TOP : q - 1'b1;
        end
    end

    assign terminal = (up == DIR_UP) ? (q == TOP) : (q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en_in) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/cascaded_mod_counter.sv
// cascaded_mod_counter
//   DIGITS cascaded modulo-MOD digits, up/down, with validated parallel load.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cascaded_mod_counter_if slave
//     en, up, load, din (in)  count enable, direction, load request, load value
//     q (out)                 packed count, digit i at [i*W +: W]
//     tc (out)                combinational terminal count (en and all digits terminal)
//     wrap (out)              registered pulse after an edge that saw tc without load
//     load_err (out)          registered pulse after a rejected load
module cascaded_mod_counter #(
    parameter int MOD    = 10,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cascaded_mod_counter_if.slave   bus
);
    import counters_pkg::*;

    localparam int W = clog2(MOD);

    logic [DIGITS-1:0] digit_ok;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] en_chain;
    logic [W-1:0]      q_d [DIGITS];
    logic              load_ok;
    logic              load_apply;

    // Range check is done one bit wider so MOD=16 does not truncate to 0.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digit_ok[i] = ({1'b0, bus.din[i*W +: W]} < (W+1)'(MOD));
        end
    end

    assign load_ok    = &digit_ok;
    assign load_apply = bus.load & load_ok;

    // A load request, accepted or rejected, suppresses counting that cycle.
    always_comb begin
        en_chain[0] = bus.en & ~bus.load;
        for (int i = 1; i < DIGITS; i++) begin
            en_chain[i] = en_chain[i-1] & term[i-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mod_n_digit #(.MOD(MOD)) u_digit (
            .clk      (clk),
            .rst      (rst),
            .en_in    (en_chain[g]),
            .up       (bus.up),
            .load     (load_apply),
            .d        (bus.din[g*W +: W]),
            .q        (q_d[g]),
            .terminal (term[g])
        );
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            bus.q[i*W +: W] = q_d[i];
        end
    end

    assign bus.tc = bus.en & (&term);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wrap     <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.wrap     <= bus.tc & ~bus.load;
            bus.load_err <= bus.load & ~load_ok;
        end
    end

endmodule

// File: tb/tb_cascaded_mod_counter.sv
// tb_cascaded_mod_counter
//   Directed bench for cascaded_mod_counter with MOD=10, DIGITS=2.
module tb_cascaded_mod_counter;

    logic clk;
    logic rst;

    int n_vec;
    int n_bad;

    cascaded_mod_counter_if #(.MOD(10), .DIGITS(2)) bus ();

    cascaded_mod_counter #(.MOD(10), .DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one rising edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bcd(input int v);
        logic [31:0] r;
        r = '0;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic do_load(input logic [7:0] val);
        bus.load = 1'b1;
        bus.din  = val;
        tick();
        bus.load = 1'b0;
    endtask

    int cnt;
    int prev;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.up = 1'b1;
        bus.load = 1'b0;
        bus.din = '0;

        // reset for 2 cycles
        tick();
        tick();
        check("rst_q", 32'(bus.q), 32'h00);
        check("rst_wrap", 32'(bus.wrap), 0);
        check("rst_err", 32'(bus.load_err), 0);
        check("rst_tc", 32'(bus.tc), 0);

        // count up through a full wrap
        rst = 1'b0;
        bus.en = 1'b1;
        bus.up = 1'b1;
        #1;
        check("up_tc0", 32'(bus.tc), 0);
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            cnt = k % 100;
            check("up_q", 32'(bus.q), bcd(cnt));
            check("up_wrap", 32'(bus.wrap), (k == 100) ? 1 : 0);
            check("up_tc", 32'(bus.tc), (cnt == 99) ? 1 : 0);
        end
        bus.en = 1'b0;
        tick();
        check("wrap_once", 32'(bus.wrap), 0);
        check("hold_q", 32'(bus.q), 32'h00);

        // load 05 and count down through a borrow wrap
        bus.up = 1'b0;
        bus.en = 1'b1;
        do_load(8'h05);
        check("dn_load_q", 32'(bus.q), 32'h05);
        check("dn_load_wrap", 32'(bus.wrap), 0);
        cnt = 5;
        for (int k = 0; k < 7; k++) begin
            prev = cnt;
            tick();
            cnt = (cnt + 99) % 100;
            check("dn_q", 32'(bus.q), bcd(cnt));
            check("dn_wrap", 32'(bus.wrap), (prev == 0) ? 1 : 0);
            check("dn_tc", 32'(bus.tc), (cnt == 0) ? 1 : 0);
        end

        // rejected load (digit 0 = 10), en high but ignored; then a good load
        bus.load = 1'b1;
        bus.din  = 8'h3A;
        bus.en   = 1'b1;
        tick();
        check("bad_q", 32'(bus.q), 32'h98);
        check("bad_err", 32'(bus.load_err), 1);
        bus.en = 1'b0;
        bus.din = 8'h39;
        tick();
        bus.load = 1'b0;
        check("good_q", 32'(bus.q), 32'h39);
        check("good_err", 32'(bus.load_err), 0);

        // carry 19 -> 20 then borrow 20 -> 19
        do_load(8'h19);
        check("cy_load", 32'(bus.q), 32'h19);
        bus.up = 1'b1;
        bus.en = 1'b1;
        #1;
        check("cy_tc", 32'(bus.tc), 0);
        tick();
        check("carry_q", 32'(bus.q), 32'h20);
        bus.up = 1'b0;
        #1;
        check("bw_tc", 32'(bus.tc), 0);
        tick();
        check("borrow_q", 32'(bus.q), 32'h19);

        // reset wins over load and en
        bus.en = 1'b0;
        do_load(8'h47);
        check("r_load", 32'(bus.q), 32'h47);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.din = 8'h55;
        bus.en = 1'b1;
        bus.up = 1'b1;
        tick();
        check("r_q", 32'(bus.q), 32'h00);
        check("r_wrap", 32'(bus.wrap), 0);
        check("r_err", 32'(bus.load_err), 0);
        rst = 1'b0;
        bus.load = 1'b0;
        tick();
        check("r_resume", 32'(bus.q), 32'h01);

        // enable dropped for 3 cycles at 62
        bus.en = 1'b0;
        do_load(8'h62);
        check("h_load", 32'(bus.q), 32'h62);
        for (int k = 0; k < 3; k++) begin
            check("h_tc_pre", 32'(bus.tc), 0);
            tick();
            check("h_q", 32'(bus.q), 32'h62);
            check("h_tc", 32'(bus.tc), 0);
        end
        bus.en = 1'b1;
        tick();
        check("h_resume", 32'(bus.q), 32'h63);

        // tc gated by en even at the terminal value
        bus.en = 1'b0;
        do_load(8'h99);
        #1;
        check("tc_en0", 32'(bus.tc), 0);
        bus.en = 1'b1;
        #1;
        check("tc_en1", 32'(bus.tc), 1);
        bus.en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
